// File: rtl/p2p_pkg.sv
// rtl/p2p_pkg.sv - shared FSM states, register offsets and constants for the PCIM generator
package p2p_pkg;

  typedef logic [1:0] w_state_t;
  localparam w_state_t W_IDLE = 2'd0;
  localparam w_state_t W_AW   = 2'd1;
  localparam w_state_t W_DATA = 2'd2;
  localparam w_state_t W_RESP = 2'd3;

  typedef logic [1:0] r_state_t;
  localparam r_state_t R_IDLE = 2'd0;
  localparam r_state_t R_AR   = 2'd1;
  localparam r_state_t R_DATA = 2'd2;

  localparam logic [7:0] OFF_WR_LO  = 8'h00;
  localparam logic [7:0] OFF_WR_HI  = 8'h04;
  localparam logic [7:0] OFF_RD_LO  = 8'h08;
  localparam logic [7:0] OFF_RD_HI  = 8'h0C;
  localparam logic [7:0] OFF_LEN    = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;

  localparam logic [31:0] BAD_READ_DATA = 32'h0BAD_F00D;

  // One 32-bit lane of write data: burst number in the top bytes, beat index in the bottom byte.
  function automatic logic [31:0] lane_word(input logic [23:0] burst, input logic [7:0] beat);
    return {burst, beat};
  endfunction

endpackage

// File: rtl/p2p_cfg_regs.sv
// rtl/p2p_cfg_regs.sv - config register file with two-cycle acknowledge pipeline
module p2p_cfg_regs
  import p2p_pkg::*;
#(
  parameter logic [31:0] CFG_BASE = 32'hF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        cfg_ack,
  output logic [31:0] cfg_rd_data,
  input  logic        wr_busy,
  input  logic        rd_busy,
  input  logic        set_bresp_err,
  input  logic        set_rresp_err,
  input  logic        set_trig_err,
  output logic [63:0] wr_addr,
  output logic [63:0] rd_addr,
  output logic [7:0]  burst_len
);

  logic [31:0] off;
  logic        in_win;
  logic [2:0]  sticky;
  logic        s1_wr;
  logic        s1_rd;
  logic        s1_in_win;
  logic [2:0]  s1_sel;
  logic [31:0] rd_mux;
  logic        status_clr;

  assign off    = cfg_addr - CFG_BASE;
  assign in_win = (cfg_addr >= CFG_BASE) && (off <= {24'd0, OFF_STATUS}) && (off[1:0] == 2'b00);
  assign status_clr = cfg_wr && in_win && (off[7:0] == OFF_STATUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr   <= '0;
      rd_addr   <= '0;
      burst_len <= '0;
    end else if (cfg_wr && in_win) begin
      case (off[7:0])
        OFF_WR_LO: wr_addr[31:0]  <= cfg_wdata;
        OFF_WR_HI: wr_addr[63:32] <= cfg_wdata;
        OFF_RD_LO: rd_addr[31:0]  <= cfg_wdata;
        OFF_RD_HI: rd_addr[63:32] <= cfg_wdata;
        OFF_LEN:   burst_len      <= cfg_wdata[7:0];
        default:   ;
      endcase
    end
  end

  // A new error event in the clearing cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
    end else begin
      sticky <= (status_clr ? 3'b000 : sticky) | {set_trig_err, set_rresp_err, set_bresp_err};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_wr     <= 1'b0;
      s1_rd     <= 1'b0;
      s1_in_win <= 1'b0;
      s1_sel    <= '0;
    end else begin
      s1_wr     <= cfg_wr;
      s1_rd     <= cfg_rd;
      s1_in_win <= in_win;
      s1_sel    <= off[4:2];
    end
  end

  always_comb begin
    rd_mux = BAD_READ_DATA;
    if (s1_in_win) begin
      case (s1_sel)
        3'd0:    rd_mux = wr_addr[31:0];
        3'd1:    rd_mux = wr_addr[63:32];
        3'd2:    rd_mux = rd_addr[31:0];
        3'd3:    rd_mux = rd_addr[63:32];
        3'd4:    rd_mux = {24'd0, burst_len};
        3'd5:    rd_mux = {27'd0, sticky, rd_busy, wr_busy};
        default: rd_mux = BAD_READ_DATA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ack     <= 1'b0;
      cfg_rd_data <= '0;
    end else begin
      cfg_ack <= s1_wr || s1_rd;
      if (s1_rd) begin
        cfg_rd_data <= rd_mux;
      end
    end
  end

endmodule

// File: rtl/p2p_pcim_gen.sv
// rtl/p2p_pcim_gen.sv - PCIM AXI burst generator: independent write and read burst FSMs
module p2p_pcim_gen
  import p2p_pkg::*;
#(
  parameter int          DATA_W   = 512,
  parameter logic [31:0] CFG_BASE = 32'hF00
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_wr,
  input  logic                cfg_rd,
  input  logic [31:0]         cfg_addr,
  input  logic [31:0]         cfg_wdata,
  output logic                cfg_ack,
  output logic [31:0]         cfg_rd_data,
  input  logic [1:0]          pcim_cntrl,
  output logic                pcim_rvalid,
  output logic                tp_tx_done,
  output logic [63:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [63:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  localparam logic [2:0] BEAT_SIZE = 3'($clog2(DATA_W / 8));

  w_state_t    wstate;
  r_state_t    rstate;
  logic [7:0]  wbeat;
  logic [23:0] burst_count;
  logic [63:0] wr_addr_cfg;
  logic [63:0] rd_addr_cfg;
  logic [7:0]  len_cfg;
  logic        b_done;
  logic        r_beat;
  logic        trig_err;
  logic        unused_rdata;

  p2p_cfg_regs #(.CFG_BASE(CFG_BASE)) u_cfg_regs (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_wr        (cfg_wr),
    .cfg_rd        (cfg_rd),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_ack       (cfg_ack),
    .cfg_rd_data   (cfg_rd_data),
    .wr_busy       (wstate != W_IDLE),
    .rd_busy       (rstate != R_IDLE),
    .set_bresp_err (b_done && (bresp != 2'b00)),
    .set_rresp_err (r_beat && (rresp != 2'b00)),
    .set_trig_err  (trig_err),
    .wr_addr       (wr_addr_cfg),
    .rd_addr       (rd_addr_cfg),
    .burst_len     (len_cfg)
  );

  assign b_done   = (wstate == W_RESP) && bvalid;
  assign r_beat   = (rstate == R_DATA) && rvalid;
  assign trig_err = (pcim_cntrl[1] && (wstate != W_IDLE)) || (pcim_cntrl[0] && (rstate != R_IDLE));

  assign awsize  = BEAT_SIZE;
  assign arsize  = BEAT_SIZE;
  assign awvalid = (wstate == W_AW);
  assign wvalid  = (wstate == W_DATA);
  assign wlast   = (wstate == W_DATA) && (wbeat == awlen);
  assign bready  = (wstate == W_RESP);
  assign arvalid = (rstate == R_AR);
  assign rready  = (rstate == R_DATA);
  assign wstrb   = '1;
  assign wdata   = {(DATA_W / 32){lane_word(burst_count, wbeat)}};

  // Read data is consumed by the far end of the test; only the handshake matters here.
  assign unused_rdata = ^rdata;

  // Address and length are sampled at trigger so config writes mid-burst hit the next burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate      <= W_IDLE;
      awaddr      <= '0;
      awlen       <= '0;
      wbeat       <= '0;
      burst_count <= '0;
      tp_tx_done  <= 1'b0;
    end else begin
      tp_tx_done <= b_done;
      case (wstate)
        W_IDLE: begin
          if (pcim_cntrl[1]) begin
            awaddr <= wr_addr_cfg;
            awlen  <= len_cfg;
            wstate <= W_AW;
          end
        end
        W_AW: begin
          if (awready) begin
            wbeat  <= '0;
            wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (wready) begin
            if (wbeat == awlen) begin
              wstate <= W_RESP;
            end else begin
              wbeat <= wbeat + 8'd1;
            end
          end
        end
        default: begin
          if (bvalid) begin
            burst_count <= burst_count + 24'd1;
            wstate      <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate      <= R_IDLE;
      araddr      <= '0;
      arlen       <= '0;
      pcim_rvalid <= 1'b0;
    end else begin
      // Held from the first beat through the rlast cycle, so it falls once per burst.
      pcim_rvalid <= r_beat || ((rstate == R_DATA) && pcim_rvalid);
      case (rstate)
        R_IDLE: begin
          if (pcim_cntrl[0]) begin
            araddr <= rd_addr_cfg;
            arlen  <= len_cfg;
            rstate <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rlast) begin
            rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2p_pcim_gen.sv
// tb/tb_p2p_pcim_gen.sv - directed self-checking bench for p2p_pcim_gen
module tb_p2p_pcim_gen;

  localparam int DATA_W = 512;
  localparam logic [31:0] BASE = 32'hF00;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_wr = 1'b0;
  logic                cfg_rd = 1'b0;
  logic [31:0]         cfg_addr = '0;
  logic [31:0]         cfg_wdata = '0;
  logic                cfg_ack;
  logic [31:0]         cfg_rd_data;
  logic [1:0]          pcim_cntrl = '0;
  logic                pcim_rvalid;
  logic                tp_tx_done;
  logic [63:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic                awvalid;
  logic                awready = 1'b0;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready = 1'b0;
  logic [1:0]          bresp = '0;
  logic                bvalid = 1'b0;
  logic                bready;
  logic [63:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic                arvalid;
  logic                arready = 1'b0;
  logic [DATA_W-1:0]   rdata = '0;
  logic [1:0]          rresp = '0;
  logic                rlast = 1'b0;
  logic                rvalid = 1'b0;
  logic                rready;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  p2p_pcim_gen #(.DATA_W(DATA_W), .CFG_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ack(cfg_ack), .cfg_rd_data(cfg_rd_data),
    .pcim_cntrl(pcim_cntrl), .pcim_rvalid(pcim_rvalid), .tp_tx_done(tp_tx_done),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [7:0] off, input logic [31:0] data);
    cfg_wr = 1'b1; cfg_addr = BASE + {24'd0, off}; cfg_wdata = data;
    step();
    cfg_wr = 1'b0;
    step();
    chk("cfg_wr_ack", {63'd0, cfg_ack}, 64'd1);
  endtask

  task automatic cfg_read(input logic [31:0] addr, output logic [31:0] data);
    cfg_rd = 1'b1; cfg_addr = addr;
    step();
    cfg_rd = 1'b0;
    chk("cfg_ack_early", {63'd0, cfg_ack}, 64'd0);
    step();
    chk("cfg_rd_ack", {63'd0, cfg_ack}, 64'd1);
    data = cfg_rd_data;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_awvalid", {63'd0, awvalid}, 64'd0);
    chk("rst_wvalid", {63'd0, wvalid}, 64'd0);
    chk("rst_bready", {63'd0, bready}, 64'd0);
    chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
    chk("rst_rready", {63'd0, rready}, 64'd0);
    chk("rst_tx_done", {63'd0, tp_tx_done}, 64'd0);
    chk("rst_pcim_rvalid", {63'd0, pcim_rvalid}, 64'd0);
    chk("rst_cfg_rd_data", {32'd0, cfg_rd_data}, 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    cfg_read(BASE + 32'h14, rd);
    chk("status_after_reset", {32'd0, rd}, 64'd0);
    step();
    chk("cfg_ack_one_wide", {63'd0, cfg_ack}, 64'd0);
    cfg_read(32'h0000_0000, rd);
    chk("out_of_window", {32'd0, rd}, 64'h0BAD_F00D);

    // len=3 write burst with awready delayed by two cycles
    cfg_write(8'h00, 32'h1000_0000);
    cfg_write(8'h04, 32'h0000_0001);
    cfg_write(8'h10, 32'd3);
    cfg_read(BASE + 32'h10, rd);
    chk("len_readback", {32'd0, rd}, 64'd3);
    pcim_cntrl = 2'b10;
    step();
    pcim_cntrl = 2'b00;
    chk("w1_awvalid", {63'd0, awvalid}, 64'd1);
    chk("w1_awaddr", awaddr, 64'h0000_0001_1000_0000);
    chk("w1_awlen", {56'd0, awlen}, 64'd3);
    chk("w1_awsize", {61'd0, awsize}, 64'd6);
    chk("w1_no_w_before_aw", {63'd0, wvalid}, 64'd0);
    step();
    chk("w1_awvalid_hold", {63'd0, awvalid}, 64'd1);
    step();
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("w1_awvalid_drop", {63'd0, awvalid}, 64'd0);
    chk("w1_wstrb", wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
    wready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      chk("w1_wvalid", {63'd0, wvalid}, 64'd1);
      chk("w1_wdata", {32'd0, wdata[31:0]}, {56'd0, 8'(n)});
      chk("w1_wlast", {63'd0, wlast}, (n == 3) ? 64'd1 : 64'd0);
      step();
    end
    wready = 1'b0;
    chk("w1_wvalid_off", {63'd0, wvalid}, 64'd0);
    chk("w1_bready", {63'd0, bready}, 64'd1);
    chk("w1_no_done_yet", {63'd0, tp_tx_done}, 64'd0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("w1_tx_done", {63'd0, tp_tx_done}, 64'd1);
    chk("w1_bready_off", {63'd0, bready}, 64'd0);
    step();
    chk("w1_tx_done_pulse", {63'd0, tp_tx_done}, 64'd0);

    // len=0 single-beat read
    cfg_write(8'h08, 32'h0000_2000);
    cfg_write(8'h0C, 32'h0);
    cfg_write(8'h10, 32'd0);
    pcim_cntrl = 2'b01;
    step();
    pcim_cntrl = 2'b00;
    chk("r1_arvalid", {63'd0, arvalid}, 64'd1);
    chk("r1_araddr", araddr, 64'h2000);
    chk("r1_arlen", {56'd0, arlen}, 64'd0);
    chk("r1_arsize", {61'd0, arsize}, 64'd6);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("r1_rready", {63'd0, rready}, 64'd1);
    chk("r1_pcim_rvalid_pre", {63'd0, pcim_rvalid}, 64'd0);
    rvalid = 1'b1; rlast = 1'b1;
    step();
    rvalid = 1'b0; rlast = 1'b0;
    chk("r1_pcim_rvalid_hi", {63'd0, pcim_rvalid}, 64'd1);
    chk("r1_rready_off", {63'd0, rready}, 64'd0);
    step();
    chk("r1_pcim_rvalid_fall", {63'd0, pcim_rvalid}, 64'd0);

    // retrigger during R_DATA
    cfg_write(8'h10, 32'd1);
    pcim_cntrl = 2'b01;
    step();
    pcim_cntrl = 2'b00;
    arready = 1'b1;
    step();
    arready = 1'b0;
    pcim_cntrl = 2'b01;
    step();
    pcim_cntrl = 2'b00;
    cfg_read(BASE + 32'h14, rd);
    chk("r2_status_busy_trig", {32'd0, rd}, 64'h12);
    rvalid = 1'b1; rlast = 1'b0;
    step();
    chk("r2_pcim_rvalid_b0", {63'd0, pcim_rvalid}, 64'd1);
    rlast = 1'b1;
    step();
    rvalid = 1'b0; rlast = 1'b0;
    chk("r2_pcim_rvalid_b1", {63'd0, pcim_rvalid}, 64'd1);
    step();
    chk("r2_pcim_rvalid_fall", {63'd0, pcim_rvalid}, 64'd0);
    chk("r2_no_retrigger", {63'd0, arvalid}, 64'd0);
    cfg_write(8'h14, 32'hFFFF_FFFF);
    cfg_read(BASE + 32'h14, rd);
    chk("r2_status_cleared", {32'd0, rd}, 64'd0);

    // both bursts at once, len=7
    cfg_write(8'h10, 32'd7);
    pcim_cntrl = 2'b11;
    step();
    pcim_cntrl = 2'b00;
    chk("b_awvalid", {63'd0, awvalid}, 64'd1);
    chk("b_arvalid", {63'd0, arvalid}, 64'd1);
    chk("b_arlen", {56'd0, arlen}, 64'd7);
    awready = 1'b1; arready = 1'b1;
    step();
    awready = 1'b0; arready = 1'b0;
    wready = 1'b1; rvalid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      rlast = (n == 7);
      chk("b_wdata", {32'd0, wdata[31:0]}, {32'd0, 24'd1, 8'(n)});
      chk("b_wlast", {63'd0, wlast}, (n == 7) ? 64'd1 : 64'd0);
      step();
    end
    chk("b_wdata_top_lane_idle", {63'd0, wvalid}, 64'd0);
    wready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    chk("b_bready", {63'd0, bready}, 64'd1);
    chk("b_rready_off", {63'd0, rready}, 64'd0);
    chk("b_pcim_rvalid_last", {63'd0, pcim_rvalid}, 64'd1);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("b_tx_done", {63'd0, tp_tx_done}, 64'd1);
    chk("b_pcim_rvalid_fall", {63'd0, pcim_rvalid}, 64'd0);
    cfg_read(BASE + 32'h14, rd);
    chk("b_status_idle", {32'd0, rd}, 64'd0);

    // bresp error then clear
    cfg_write(8'h10, 32'd0);
    pcim_cntrl = 2'b10;
    step();
    pcim_cntrl = 2'b00;
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("e_wdata", {32'd0, wdata[31:0]}, 64'h0000_0200);
    chk("e_wdata_top", {32'd0, wdata[511:480]}, 64'h0000_0200);
    chk("e_wlast", {63'd0, wlast}, 64'd1);
    wready = 1'b1;
    step();
    wready = 1'b0;
    bvalid = 1'b1; bresp = 2'b10;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    chk("e_tx_done", {63'd0, tp_tx_done}, 64'd1);
    cfg_read(BASE + 32'h14, rd);
    chk("e_status_bresp", {32'd0, rd}, 64'h04);
    cfg_write(8'h14, 32'h0);
    cfg_read(BASE + 32'h14, rd);
    chk("e_status_clear", {32'd0, rd}, 64'd0);

    // reset during W_DATA beat 2
    cfg_write(8'h10, 32'd3);
    pcim_cntrl = 2'b10;
    step();
    pcim_cntrl = 2'b00;
    awready = 1'b1;
    step();
    awready = 1'b0;
    wready = 1'b1;
    step();
    step();
    chk("x_beat2_data", {32'd0, wdata[31:0]}, 64'h0000_0302);
    rst_n = 1'b0;
    #1;
    chk("x_wvalid_rst", {63'd0, wvalid}, 64'd0);
    chk("x_bready_rst", {63'd0, bready}, 64'd0);
    wready = 1'b0;
    step();
    chk("x_no_tx_done", {63'd0, tp_tx_done}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("x_no_tx_done2", {63'd0, tp_tx_done}, 64'd0);
    pcim_cntrl = 2'b10;
    step();
    pcim_cntrl = 2'b00;
    chk("x_restart_aw", {63'd0, awvalid}, 64'd1);
    chk("x_awlen_reset", {56'd0, awlen}, 64'd0);
    chk("x_awaddr_reset", awaddr, 64'd0);
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("x_count_reset", {32'd0, wdata[31:0]}, 64'd0);
    wready = 1'b1;
    step();
    wready = 1'b0;
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("x_tx_done", {63'd0, tp_tx_done}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
